// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared widths, opcode encodings and fetch-state type for the
//                16-bit pipelined CPU.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;

    // Opcode field (instr[15:12]) encodings
    localparam logic [3:0] OP_HALT  = 4'h0;
    localparam logic [3:0] OP_ANDI  = 4'h1;
    localparam logic [3:0] OP_ORI   = 4'h2;
    localparam logic [3:0] OP_BGT   = 4'h4;
    localparam logic [3:0] OP_BLT   = 4'h5;
    localparam logic [3:0] OP_BEQ   = 4'h6;
    localparam logic [3:0] OP_LBU   = 4'hA;
    localparam logic [3:0] OP_SB    = 4'hB;
    localparam logic [3:0] OP_LW    = 4'hC;
    localparam logic [3:0] OP_SW    = 4'hD;
    localparam logic [3:0] OP_RTYPE = 4'hF;

    // Encoding inserted into a pipeline register that carries no instruction
    localparam logic [INSTR_W-1:0] BUBBLE_WORD = 16'h0000;

    // Fetch run/halt state
    typedef enum logic [0:0] {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : Generic pipeline register with hold enable and synchronous
//                flush. Flush wins over enable and clears the stage to zero,
//                which reads downstream as an invalid bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg #(
    parameter int WIDTH = 49
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_data;

    // Stage storage: async clear, flush to bubble, otherwise load when enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (flush) begin
            r_data <= '0;
        end else if (en) begin
            r_data <= d;
        end
    end

    assign q = r_data;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_unit
//  Description : Fetch stage. Owns the PC, addresses instruction memory,
//                latches the returned word into IF/ID, and handles stall,
//                branch redirect/flush, HALT detection and fetch counting.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC  = 16'h0000,
    parameter logic [ADDR_W-1:0]  PC_STEP   = 16'd2,
    parameter logic [INSTR_W-1:0] HALT_WORD = 16'h0000,
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic [ADDR_W-1:0]  pc_out,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic [ADDR_W-1:0]  ifid_pc_plus2,
    output logic               ifid_valid,
    output logic               halted,
    output logic               misalign,
    output logic [CNT_W-1:0]   fetch_count
);

    localparam int IFID_W = 1 + INSTR_W + 2 * ADDR_W;

    fetch_state_t       r_state, w_state_next;
    logic [ADDR_W-1:0]  r_pc, w_pc_next, w_pc_inc;
    logic               r_misalign, w_misalign_next;
    logic [CNT_W-1:0]   r_count;
    logic               w_load, w_flush;
    logic [IFID_W-1:0]  w_ifid_d, w_ifid_q;

    // Sequential address wraps naturally at 16 bits
    assign w_pc_inc = r_pc + PC_STEP;

    // State register, PC, sticky misalign flag and fetch counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= FS_RUN;
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_misalign <= w_misalign_next;
            if (w_load) begin
                r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Next-state decode: redirect > stall > halted > normal fetch
    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_misalign_next = r_misalign;
        w_load          = 1'b0;
        w_flush         = 1'b0;
        if (redirect_valid) begin
            // Bit 0 is dropped so fetch stays halfword aligned
            w_pc_next       = {redirect_target[ADDR_W-1:1], 1'b0};
            w_flush         = 1'b1;
            w_state_next    = FS_RUN;
            w_misalign_next = r_misalign | redirect_target[0];
        end else if (stall) begin
            w_pc_next = r_pc;
        end else if (r_state == FS_HALT) begin
            w_flush = 1'b1;
        end else begin
            w_load = 1'b1;
            if (instr_in == HALT_WORD) begin
                w_state_next = FS_HALT;
            end else begin
                w_pc_next = w_pc_inc;
            end
        end
    end

    assign w_ifid_d = {1'b1, instr_in, r_pc, w_pc_inc};

    if_id_reg #(
        .WIDTH (IFID_W)
    ) u_if_id_reg (
        .clk   (clk),
        .rst   (rst),
        .en    (w_load),
        .flush (w_flush),
        .d     (w_ifid_d),
        .q     (w_ifid_q)
    );

    assign {ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus2} = w_ifid_q;

    assign pc_out      = r_pc;
    assign halted      = (r_state == FS_HALT);
    assign misalign    = r_misalign;
    assign fetch_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch_unit
//  Description : Self-checking bench for instruction_fetch_unit with a
//                rule-level reference model and a small program image.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic [15:0] pc_out;
    logic [15:0] instr_in;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_pc_plus2;
    logic        ifid_valid;
    logic        halted;
    logic        misalign;
    logic [15:0] fetch_count;

    int tests = 0;
    int fails = 0;

    // Program image: 32 halfwords at 0x0000..0x003E, everything else reads 0
    logic [15:0] img [32];
    logic        force_en;
    logic [15:0] force_val;

    // Reference model state
    logic [15:0] m_pc, m_instr, m_ipc, m_ipc2, m_cnt;
    logic        m_valid, m_halt, m_mis;

    instruction_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc_out          (pc_out),
        .instr_in        (instr_in),
        .ifid_instr      (ifid_instr),
        .ifid_pc         (ifid_pc),
        .ifid_pc_plus2   (ifid_pc_plus2),
        .ifid_valid      (ifid_valid),
        .halted          (halted),
        .misalign        (misalign),
        .fetch_count     (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_read(input logic [15:0] a);
        if (a < 16'h0040) return img[a[5:1]];
        return 16'h0000;
    endfunction

    assign instr_in = force_en ? force_val : mem_read(pc_out);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000; m_ipc2 = 16'h0000;
        m_cnt = 16'h0000; m_valid = 1'b0; m_halt = 1'b0; m_mis = 1'b0;
    endtask

    task automatic check_all();
        chk("pc_out", pc_out, m_pc);
        chk("ifid_valid", ifid_valid, m_valid);
        chk("ifid_instr", ifid_instr, m_instr);
        chk("halted", halted, m_halt);
        chk("misalign", misalign, m_mis);
        chk("fetch_count", fetch_count, m_cnt);
        if (m_valid) begin
            chk("ifid_pc", ifid_pc, m_ipc);
            chk("ifid_pc_plus2", ifid_pc_plus2, m_ipc2);
        end
    endtask

    // Advance the model by one edge using the current inputs, then check
    task automatic cycle();
        logic [15:0] ins;
        ins = force_en ? force_val : mem_read(m_pc);
        if (redirect_valid) begin
            m_pc    = redirect_target & 16'hFFFE;
            m_valid = 1'b0;
            m_instr = 16'h0000;
            m_halt  = 1'b0;
            m_mis   = m_mis | redirect_target[0];
        end else if (stall) begin
            m_pc = m_pc;
        end else if (m_halt) begin
            m_valid = 1'b0;
            m_instr = 16'h0000;
        end else begin
            m_instr = ins;
            m_ipc   = m_pc;
            m_ipc2  = m_pc + 16'd2;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 16'd1;
            if (ins == 16'h0000) m_halt = 1'b1;
            else                 m_pc   = m_pc + 16'd2;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    typedef struct {
        logic        stall;
        logic [15:0] exp_pc;
        logic [15:0] exp_instr;
        logic [15:0] exp_ipc;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [7];

    initial begin
        for (int i = 0; i < 32; i++) img[i] = 16'h1100 + 16'(i) * 16'h0101;
        img[0]  = 16'hFE21;
        img[1]  = 16'hFB22;
        img[2]  = 16'h2388;
        img[3]  = 16'h149A;
        img[24] = 16'hC890;
        img[31] = 16'h0000;

        vecs[0] = '{1'b0, 16'h0002, 16'hFE21, 16'h0000, 16'd1};
        vecs[1] = '{1'b0, 16'h0004, 16'hFB22, 16'h0002, 16'd2};
        vecs[2] = '{1'b0, 16'h0006, 16'h2388, 16'h0004, 16'd3};
        vecs[3] = '{1'b1, 16'h0006, 16'h2388, 16'h0004, 16'd3};
        vecs[4] = '{1'b1, 16'h0006, 16'h2388, 16'h0004, 16'd3};
        vecs[5] = '{1'b1, 16'h0006, 16'h2388, 16'h0004, 16'd3};
        vecs[6] = '{1'b0, 16'h0008, 16'h149A, 16'h0006, 16'd4};

        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 16'h0000;
        force_en = 1'b0; force_val = 16'h0000;
        model_reset();
        #12;
        check_all();
        rst = 1'b0;

        // Free run from reset and a three-cycle stall
        for (int i = 0; i < 7; i++) begin
            stall = vecs[i].stall;
            cycle();
            chk("tbl_pc", pc_out, vecs[i].exp_pc);
            chk("tbl_instr", ifid_instr, vecs[i].exp_instr);
            chk("tbl_ifid_pc", ifid_pc, vecs[i].exp_ipc);
            chk("tbl_count", fetch_count, vecs[i].exp_cnt);
        end
        stall = 1'b0;

        // Run to 0x0024, redirect to 0x0030
        for (int n = 0; n < 40 && pc_out != 16'h0024; n++) cycle();
        chk("reach_0024", pc_out, 16'h0024);
        redirect_valid = 1'b1; redirect_target = 16'h0030;
        cycle();
        redirect_valid = 1'b0;
        chk("redir_valid", ifid_valid, 1'b0);
        chk("redir_pc", pc_out, 16'h0030);
        cycle();
        chk("redir_instr", ifid_instr, 16'hC890);
        chk("redir_ifid_pc", ifid_pc, 16'h0030);

        // Run into the HALT word at 0x003E
        for (int n = 0; n < 20 && !halted; n++) cycle();
        chk("halt_flag", halted, 1'b1);
        chk("halt_instr", ifid_instr, 16'h0000);
        chk("halt_valid", ifid_valid, 1'b1);
        chk("halt_ifid_pc", ifid_pc, 16'h003E);
        for (int n = 0; n < 3; n++) begin
            cycle();
            chk("halt_bubble", ifid_valid, 1'b0);
            chk("halt_pc", pc_out, 16'h003E);
        end
        redirect_valid = 1'b1; redirect_target = 16'h0000;
        cycle();
        redirect_valid = 1'b0;
        chk("unhalt", halted, 1'b0);
        cycle();
        chk("unhalt_instr", ifid_instr, 16'hFE21);

        // Misaligned redirect together with stall
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 16'h0033;
        cycle();
        stall = 1'b0; redirect_valid = 1'b0;
        chk("mis_pc", pc_out, 16'h0032);
        chk("mis_flag", misalign, 1'b1);
        cycle(); cycle();
        chk("mis_sticky", misalign, 1'b1);

        // PC wrap with a forced non-halt instruction
        force_en = 1'b1; force_val = 16'h1234;
        redirect_valid = 1'b1; redirect_target = 16'hFFFE;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        chk("wrap_pc", pc_out, 16'h0000);
        chk("wrap_ifid_pc", ifid_pc, 16'hFFFE);
        chk("wrap_plus2", ifid_pc_plus2, 16'h0000);

        // Unmapped 0xFFFE reads as HALT
        force_en = 1'b0;
        redirect_valid = 1'b1; redirect_target = 16'hFFFE;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        chk("ffe_halt", halted, 1'b1);
        chk("ffe_pc", pc_out, 16'hFFFE);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            stall           = ($urandom % 4) == 0;
            redirect_valid  = ($urandom % 6) == 0;
            redirect_target = (($urandom % 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
            force_en        = ($urandom % 8) == 0;
            force_val       = 16'($urandom);
            cycle();
        end
        stall = 1'b0; redirect_valid = 1'b0; force_en = 1'b0;

        // Asynchronous reset mid-run, between clock edges
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("async_pc2", ifid_pc_plus2, 16'h0000);
        #1;
        rst = 1'b0;
        cycle();
        chk("post_rst_instr", ifid_instr, 16'hFE21);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
